// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add front end: field widths, constants,
// the unpacked-operand record and the alignment shifter.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned MANT_W = 27;
    localparam int unsigned BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;      // raw biased exponent
        logic [EXP_W-1:0]  eff_exp;  // denormals report 1
        logic [FRAC_W:0]   mant;     // {hidden, frac}
        logic              is_nan;
        logic              is_inf;
        logic              is_zero;
    } unpacked_t;

    // Right-shift {mant,GRS} by d; every bit pushed past the LSB folds into the sticky bit.
    function automatic logic [MANT_W-1:0] align_shift(input logic [FRAC_W:0] mant,
                                                      input logic [EXP_W-1:0] d);
        logic [MANT_W-1:0] ext;
        logic [MANT_W-1:0] shifted;
        logic [MANT_W-1:0] lost_mask;
        ext = {mant, 3'b000};
        if (int'(d) >= int'(MANT_W)) begin
            align_shift = (|mant) ? MANT_W'(1) : MANT_W'(0);
        end else begin
            shifted     = ext >> d;
            lost_mask   = ~({MANT_W{1'b1}} << d);
            align_shift = {shifted[MANT_W-1:1], shifted[0] | (|(ext & lost_mask))};
        end
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 single unpacker: sign, effective exponent, mantissa with hidden bit
// and NaN/Inf/zero classification.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0] op,
    output unpacked_t   u
);

    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;

    assign exp_f  = op[30:23];
    assign frac_f = op[22:0];

    always_comb begin
        u         = '0;
        u.sign    = op[31];
        u.exp     = exp_f;
        u.eff_exp = (exp_f == '0) ? EXP_W'(1) : exp_f;
        u.mant    = {(exp_f != '0), frac_f};
        u.is_nan  = (exp_f == EXP_MAX) && (frac_f != '0);
        u.is_inf  = (exp_f == EXP_MAX) && (frac_f == '0);
        u.is_zero = (exp_f == '0) && (frac_f == '0);
    end

endmodule

// File: rtl/fp_align_stage.sv
// Two-stage alignment front end of an FP adder: S1 unpacks, compares and swaps operands,
// S2 aligns the smaller mantissa and resolves NaN/Inf/zero bypass results.
module fp_align_stage
    import fp_pkg::*;
#(
    parameter int N = 32  // only 32 is supported
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         sign_l,
    output logic         sign_s,
    output logic [7:0]   exp_out,
    output logic [26:0]  mant_l,
    output logic [26:0]  mant_s,
    output logic         eff_sub,
    output logic         special,
    output logic [N-1:0] special_val
);

    unpacked_t ua;
    unpacked_t ub;
    unpacked_t l_d;
    unpacked_t s_d;
    unpacked_t s1_l;
    unpacked_t s1_s;
    logic      s1_valid;
    logic      s2_valid;
    logic      s1_en;
    logic      s2_en;
    logic      a_is_l;

    fp_unpack u_unpack_a (
        .op (A),
        .u  (ua)
    );

    fp_unpack u_unpack_b (
        .op (B),
        .u  (ub)
    );

    // Magnitude compare on {exp,frac}; ties keep A as the larger operand.
    assign a_is_l = (A[30:0] >= B[30:0]);
    assign l_d    = a_is_l ? ua : ub;
    assign s_d    = a_is_l ? ub : ua;

    assign s2_en     = !s2_valid || out_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_l     <= '0;
            s1_s     <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_l <= l_d;
                s1_s <= s_d;
            end
        end
    end

    logic [EXP_W-1:0]  shift_amt;
    logic [MANT_W-1:0] mant_s_d;
    logic              special_d;
    logic [31:0]       special_val_d;

    assign shift_amt = s1_l.eff_exp - s1_s.eff_exp;
    assign mant_s_d  = align_shift(s1_s.mant, shift_amt);

    always_comb begin
        special_d     = 1'b0;
        special_val_d = '0;
        if (s1_l.is_nan || s1_s.is_nan ||
            (s1_l.is_inf && s1_s.is_inf && (s1_l.sign != s1_s.sign))) begin
            special_d     = 1'b1;
            special_val_d = QNAN;
        end else if (s1_l.is_inf || s1_s.is_inf) begin
            special_d     = 1'b1;
            special_val_d = {(s1_l.is_inf ? s1_l.sign : s1_s.sign), EXP_MAX, 23'd0};
        end else if (s1_l.is_zero && s1_s.is_zero) begin
            special_d     = 1'b1;
            special_val_d = {(s1_l.sign & s1_s.sign), 31'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid    <= 1'b0;
            sign_l      <= 1'b0;
            sign_s      <= 1'b0;
            exp_out     <= '0;
            mant_l      <= '0;
            mant_s      <= '0;
            eff_sub     <= 1'b0;
            special     <= 1'b0;
            special_val <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                sign_l      <= s1_l.sign;
                sign_s      <= s1_s.sign;
                exp_out     <= s1_l.exp;
                mant_l      <= {s1_l.mant, 3'b000};
                mant_s      <= mant_s_d;
                eff_sub     <= s1_l.sign ^ s1_s.sign;
                special     <= special_d;
                special_val <= special_val_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_align_stage.sv
// Self-checking bench for fp_align_stage: directed vectors, a back-to-back stream with a
// downstream stall, and reset with pairs in flight.
module tb_fp_align_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        sign_l;
    logic        sign_s;
    logic [7:0]  exp_out;
    logic [26:0] mant_l;
    logic [26:0] mant_s;
    logic        eff_sub;
    logic        special;
    logic [31:0] special_val;

    always #5 clk = ~clk;

    fp_align_stage #(.N(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .A           (A),
        .B           (B),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sign_l      (sign_l),
        .sign_s      (sign_s),
        .exp_out     (exp_out),
        .mant_l      (mant_l),
        .mant_s      (mant_s),
        .eff_sub     (eff_sub),
        .special     (special),
        .special_val (special_val)
    );

    typedef struct packed {
        logic        sl;
        logic        ss;
        logic [7:0]  ex;
        logic [26:0] ml;
        logic [26:0] ms;
        logic        es;
        logic        sp;
        logic [31:0] sv;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;
    bit   seen_full = 0;
    bit   post_reset = 0;
    bit   stalled = 0;
    exp_t held;
    exp_t act;
    exp_t want;

    task automatic check(input string name, input logic [127:0] actual,
                         input logic [127:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    function automatic exp_t mk(input logic sl_, input logic ss_, input logic [7:0] ex_,
                                input logic [26:0] ml_, input logic [26:0] ms_,
                                input logic es_, input logic sp_, input logic [31:0] sv_);
        exp_t e;
        e.sl = sl_; e.ss = ss_; e.ex = ex_; e.ml = ml_; e.ms = ms_;
        e.es = es_; e.sp = sp_; e.sv = sv_;
        return e;
    endfunction

    // Aligned fields are don't-care when a bypass result is flagged.
    function automatic exp_t mask(input exp_t e);
        exp_t m;
        m = e;
        if (e.sp) begin
            m.sl = 0; m.ss = 0; m.ex = 0; m.ml = 0; m.ms = 0; m.es = 0;
        end
        return m;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] l;
        logic [31:0] s;
        int          el;
        int          es;
        int          d;
        longint      ml;
        longint      ms;
        longint      qt;
        longint      rm;
        longint      al;
        bit          nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        if (a[30:0] >= b[30:0]) begin l = a; s = b; end
        else begin l = b; s = a; end
        el = (l[30:23] == 0) ? 1 : int'(l[30:23]);
        es = (s[30:23] == 0) ? 1 : int'(s[30:23]);
        ml = ((l[30:23] != 0) ? 64'h80_0000 : 64'h0) + longint'(l[22:0]);
        ms = ((s[30:23] != 0) ? 64'h80_0000 : 64'h0) + longint'(s[22:0]);
        ml = ml * 8;
        ms = ms * 8;
        d = el - es;
        if (d >= 27) begin
            al = (ms != 0) ? 1 : 0;
        end else begin
            qt = ms >> d;
            rm = ms - (qt << d);
            al = qt | ((rm != 0) ? 64'd1 : 64'd0);
        end
        nan_a  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nan_b  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        inf_a  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        inf_b  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        zero_a = (a[30:0] == 0);
        zero_b = (b[30:0] == 0);
        e = mk(l[31], s[31], l[30:23], ml[26:0], al[26:0], l[31] ^ s[31], 1'b0, 32'h0);
        if (nan_a || nan_b || (inf_a && inf_b && a[31] != b[31])) begin
            e.sp = 1; e.sv = 32'h7FC0_0000;
        end else if (inf_a) begin
            e.sp = 1; e.sv = a;
        end else if (inf_b) begin
            e.sp = 1; e.sv = b;
        end else if (zero_a && zero_b) begin
            e.sp = 1; e.sv = (a[31] && b[31]) ? 32'h8000_0000 : 32'h0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        act = mk(sign_l, sign_s, exp_out, mant_l, mant_s, eff_sub, special, special_val);
        if (post_reset) begin
            check("reset_out_valid", out_valid, 0);
            check("reset_in_ready", in_ready, 1);
            check("reset_data", act, 0);
            post_reset = 0;
        end
        if (reset) begin
            q.delete();
            post_reset = 1;
            stalled = 0;
        end else begin
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", act, held);
            end
            check("in_ready", in_ready, !(q.size() == 2 && !out_ready));
            if (!in_ready) seen_full = 1;
            if (out_valid && q.size() == 0) begin
                check("spurious_output", out_valid, 0);
            end else if (out_valid && out_ready) begin
                want = q.pop_front();
                popped++;
                check("out_pair", mask(act), mask(want));
            end
            stalled = out_valid && !out_ready;
            held = act;
            if (in_valid && in_ready) begin
                q.push_back(model(A, B));
                pushed++;
            end
        end
    end

    // Entered at posedge+1; returns at posedge+1 just after the pair was accepted.
    task automatic drive_pair(input logic [31:0] a, input logic [31:0] b);
        bit rdy;
        bit done;
        done = 0;
        in_valid = 1; A = a; B = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            done = rdy;
        end
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic lit(input logic [31:0] a, input logic [31:0] b, input exp_t w,
                       input string tag);
        check({"model_", tag}, mask(model(a, b)), mask(w));
        @(posedge clk); #1;
        out_ready = 1;
        in_valid = 1; A = a; B = b;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        check({"lat_valid_", tag}, out_valid, 1);
        check({"dut_", tag},
              mask(mk(sign_l, sign_s, exp_out, mant_l, mant_s, eff_sub, special, special_val)),
              mask(w));
    endtask

    logic [31:0] la[12];
    logic [31:0] lb[12];
    exp_t        lw[12];
    logic [31:0] sa[4];
    logic [31:0] sb[4];

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        reset = 1; in_valid = 0; out_ready = 1; A = 0; B = 0;
        la[0]  = 32'h4070_0000; lb[0]  = 32'h40C8_0000;
        lw[0]  = mk(0, 0, 8'h81, 27'h640_0000, 27'h3C0_0000, 0, 0, 0);
        la[1]  = 32'h4316_0000; lb[1]  = 32'h4020_0000;
        lw[1]  = mk(0, 0, 8'h86, 27'h4B0_0000, 27'h014_0000, 0, 0, 0);
        la[2]  = 32'h3F80_0000; lb[2]  = 32'h3080_0000;
        lw[2]  = mk(0, 0, 8'h7F, 27'h400_0000, 27'h000_0001, 0, 0, 0);
        la[3]  = 32'h7F80_0000; lb[3]  = 32'hFF80_0000;
        lw[3]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h7FC0_0000);
        la[4]  = 32'hC000_0000; lb[4]  = 32'h3F80_0000;
        lw[4]  = mk(1, 0, 8'h80, 27'h400_0000, 27'h200_0000, 1, 0, 0);
        la[5]  = 32'h4B00_0000; lb[5]  = 32'h3FC0_0001;
        lw[5]  = mk(0, 0, 8'h96, 27'h400_0000, 27'h000_000D, 0, 0, 0);
        la[6]  = 32'h0000_0003; lb[6]  = 32'h0080_0000;
        lw[6]  = mk(0, 0, 8'h01, 27'h400_0000, 27'h000_0018, 0, 0, 0);
        la[7]  = 32'h3F80_0000; lb[7]  = 32'hBF80_0000;
        lw[7]  = mk(0, 1, 8'h7F, 27'h400_0000, 27'h400_0000, 1, 0, 0);
        la[8]  = 32'h8000_0000; lb[8]  = 32'h8000_0000;
        lw[8]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h8000_0000);
        la[9]  = 32'h7F80_0000; lb[9]  = 32'h3F80_0000;
        lw[9]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h7F80_0000);
        la[10] = 32'h3F80_0000; lb[10] = 32'h7FA0_0000;
        lw[10] = mk(0, 0, 0, 0, 0, 0, 1, 32'h7FC0_0000);
        la[11] = 32'h8000_0000; lb[11] = 32'h0000_0000;
        lw[11] = mk(0, 0, 0, 0, 0, 0, 1, 32'h0000_0000);
        sa[0] = 32'h4070_0000; sb[0] = 32'h40C8_0000;
        sa[1] = 32'h4316_0000; sb[1] = 32'h4020_0000;
        sa[2] = 32'hC000_0000; sb[2] = 32'h3F80_0000;
        sa[3] = 32'h4B00_0000; sb[3] = 32'h3FC0_0001;

        repeat (2) @(posedge clk);
        #1 reset = 0;

        for (int i = 0; i < 12; i++) lit(la[i], lb[i], lw[i], $sformatf("v%0d", i));

        // Back-to-back stream with a 3-cycle downstream stall.
        @(posedge clk); #1;
        seen_full = 0;
        pushed = 0;
        popped = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) drive_pair(sa[i], sb[i]);
                in_valid = 0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        for (int i = 0; i < 50 && q.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        check("stream_drained", q.size(), 0);
        check("stream_count", popped, 4);
        check("stream_accepted", pushed, 4);
        check("in_ready_low_when_full", seen_full, 1);

        // Reset with two pairs held in the pipeline.
        @(posedge clk); #1;
        out_ready = 0;
        drive_pair(32'h4070_0000, 32'h40C8_0000);
        drive_pair(32'h4316_0000, 32'h4020_0000);
        in_valid = 0;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check("reset_next_out_valid", out_valid, 0);
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_stale_output", out_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_align_stage.md
FP_ALIGN_STAGE -- requirements
Module: fp_align_stage

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand width; only 32 (IEEE-754 single) is legal.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port A, input, N, the first IEEE-754 single operand.
REQ-005 SHALL have port B, input, N, the second IEEE-754 single operand.
REQ-006 SHALL have port in_valid, input, 1, meaning A/B hold a valid operand pair.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts a pair this cycle.
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1) as the downstream handshake to the mantissa adder.
REQ-009 SHALL have ports sign_l and sign_s, output, 1 each, the signs of the larger- and smaller-magnitude operands.
REQ-010 SHALL have port exp_out, output, 8, the biased exponent of the larger operand.
REQ-011 SHALL have ports mant_l and mant_s, output, 27 each, formatted {hidden, frac[22:0], G, R, S}.
REQ-012 SHALL have port eff_sub, output, 1, equal to sign_l XOR sign_s.
REQ-013 SHALL have ports special (output, 1) and special_val (output, N), a bypass result for NaN/Inf/zero cases.

Function
REQ-014 SHALL transfer data on in_valid && in_ready (input side) and on out_valid && out_ready (output side).
REQ-015 SHALL be a 2-stage pipeline: S1 unpacks, compares and swaps; S2 shifts and handles specials; latency is 2 cycles with out_ready held high.
REQ-016 SHALL sustain one pair per cycle: in_ready = !s1_valid || !s2_valid || out_ready.
REQ-017 SHALL hold output data stable while out_valid && !out_ready.
REQ-018 SHALL set hidden bit 1 for exponent != 0; a denormal (exponent 0) gets hidden bit 0 and effective exponent 1.
REQ-019 SHALL compare {exp,frac} unsigned; the larger becomes the L operand, and on a tie A is L.
REQ-020 SHALL use shift amount d = effexp_L - effexp_S; mant_s = {mant_S,000} >> d, with S = OR of all bits shifted out.
REQ-021 SHALL, when d >= 27, drive mant_s = 27'h0000001 if mant_S != 0, else 0.
REQ-022 SHALL set special=1 and special_val=32'h7FC00000 when either operand is NaN, or for +Inf plus -Inf.
REQ-023 SHALL set special=1 with special_val equal to the infinity when exactly one sign of infinity is present.
REQ-024 SHALL set special=1 for both operands zero, with special_val -0 only if both are -0, else +0.
REQ-025 SHALL drive special=0 otherwise; the aligned fields are still driven when special=1 and are don't-care to the consumer.

Reset
REQ-026 SHALL clear s1_valid and s2_valid on reset, so out_valid=0 and in_ready=1 in the next cycle.
REQ-027 SHALL reset all data outputs to 0; reset mid-operation drops in-flight pairs with no partial output.

Structure
REQ-028 SHALL place the following in a shared package fp_pkg: field widths (EXP_W=8, FRAC_W=23, MANT_W=27), BIAS=127, the QNAN constant, and the unpacked-operand struct.
REQ-029 SHALL instantiate one sub-module, fp_unpack (combinational; yields sign, effective exponent, mantissa with hidden bit, isNaN, isInf, isZero), once per operand.

Verification
REQ-030 SHALL verify A=0x40700000 (3.75), B=0x40C80000 (6.25) -> after 2 cycles: sign_l=0, exp_out=0x81, mant_l=0x6400000, mant_s=0x3C00000, eff_sub=0, special=0.
REQ-031 SHALL verify A=0x43160000 (150), B=0x40200000 (2.5) -> exp_out=0x86, mant_l=0x4B00000, mant_s=0x0140000.
REQ-032 SHALL verify A=0x3F800000, B=0x30800000 (d=30) -> mant_s=0x0000001 (sticky only).
REQ-033 SHALL verify A=0x7F800000, B=0xFF800000 -> special=1, special_val=0x7FC00000.
REQ-034 SHALL verify a 4-pair back-to-back stream with out_ready low for 3 cycles mid-stream -> no loss or duplication, in-order outputs, in_ready low while full.
REQ-035 SHALL verify reset asserted with 2 pairs in flight -> out_valid=0 next cycle and no stale pair emitted afterward.
